// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed little-endian byte image into instruction memory
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              processor_rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              program_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, FIN, ERR} state_t;
  state_t            state;
  logic [1:0]        byteCnt;
  logic [31:0]       shiftReg;
  logic [ADDR_W:0]   wordCnt;
  logic [ADDR_W:0]   lenReg;
  logic              accept;
  logic              lastByte;
  logic              lenBad;
  logic [31:0]       nextWord;
  assign accept   = rx_valid && rx_ready;
  assign lastByte = accept && byteCnt == 2'd3;
  assign nextWord = {rx_data, shiftReg[31:8]};
  assign lenBad   = nextWord == 32'd0 || {1'b0, nextWord} > (33'd1 << ADDR_W);
  assign rx_ready = state == HDR || state == DATA;
  assign busy     = rx_ready;
  assign err      = state == ERR;
  // Load sequencer: byte assembly, header check, word writes and pipeline-reset control
  always_ff @(posedge clk) begin
    if (processor_rst) begin
      state       <= IDLE;
      program_rst <= 1'b1;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      done        <= 1'b0;
      byteCnt     <= '0;
      shiftReg    <= '0;
      wordCnt     <= '0;
      lenReg      <= '0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      if (im_we) im_addr <= im_addr + 1'b1;
      if (accept) begin
        shiftReg <= nextWord;
        byteCnt  <= byteCnt + 1'b1;
      end
      case (state)
        IDLE, ERR: if (start) begin
          state       <= HDR;
          program_rst <= 1'b1;
          byteCnt     <= '0;
          wordCnt     <= '0;
          im_addr     <= '0;
        end
        HDR: if (lastByte) begin
          state  <= lenBad ? ERR : DATA;
          lenReg <= nextWord[ADDR_W:0];
        end
        DATA: if (lastByte) begin
          im_we    <= 1'b1;
          im_wdata <= nextWord;
          wordCnt  <= wordCnt + 1'b1;
          if (wordCnt + 1'b1 == lenReg) begin
            state       <= FIN;
            program_rst <= 1'b0;
            done        <= 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the program loader
module tb_program_loader;
  logic        clk = 1'b0;
  logic        processor_rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, im_we, program_rst, busy, done, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  int tests = 0, fails = 0;
  int nDone = 0, finPr = 0;
  logic [7:0]  qa[$];
  logic [31:0] qd[$];
  logic [31:0] gw[3] = '{32'd2, 32'h00500513, 32'h00A00593};

  program_loader #(.ADDR_W(8)) dut (
    .clk(clk), .processor_rst(processor_rst), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .program_rst(program_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Log every memory write and done pulse, and whether program_rst was still high at done
  always @(negedge clk) begin
    if (im_we) begin
      qa.push_back(im_addr);
      qd.push_back(im_wdata);
    end
    if (done) begin
      nDone++;
      if (program_rst) finPr++;
    end
  end

  task tick; @(posedge clk); #1; endtask
  task clearLog; qa.delete(); qd.delete(); nDone = 0; finPr = 0; endtask
  task doReset;
    processor_rst = 1; start = 0; rx_valid = 0; rx_data = 0;
    tick;
    processor_rst = 0;
    clearLog;
  endtask
  task doStart; start = 1; tick; start = 0; endtask
  task sendByte(input logic [7:0] b); rx_valid = 1; rx_data = b; tick; rx_valid = 0; endtask
  task sendWord(input logic [31:0] w); for (int i = 0; i < 4; i++) sendByte(w[8*i+:8]); endtask

  task test_reset;
    doReset;
    tests++;
    if ({rx_ready, im_we, program_rst, busy, done, err} !== 6'b001000 || im_addr !== 8'd0 || im_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got ctl=%b addr=%h data=%h, want ctl=001000 addr=00 data=00000000",
        {rx_ready, im_we, program_rst, busy, done, err}, im_addr, im_wdata);
    end
  endtask

  task test_normal;
    doReset;
    doStart;
    tests++;
    if ({busy, rx_ready, program_rst, err} !== 4'b1110) begin
      fails++; $display("FAIL normal_hdr_entry: got busy/rdy/prst/err=%b want 1110", {busy, rx_ready, program_rst, err});
    end
    for (int k = 0; k < 3; k++) sendWord(gw[k]);
    tests++;
    if ({im_we, done, program_rst, rx_ready} !== 4'b1100) begin
      fails++; $display("FAIL normal_fin_cycle: got we/done/prst/rdy=%b want 1100", {im_we, done, program_rst, rx_ready});
    end
    tick; tick;
    tests++;
    if ({program_rst, busy, done} !== 3'b000) begin
      fails++; $display("FAIL normal_idle_after: got prst/busy/done=%b want 000", {program_rst, busy, done});
    end
    tests++;
    if (qa.size() != 2 || qa[0] !== 8'd0 || qd[0] !== 32'h00500513 || qa[1] !== 8'd1 || qd[1] !== 32'h00A00593) begin
      fails++; $display("FAIL normal_writes: got %0d writes first=%h@%h, want 2 writes 00500513@00 00A00593@01",
        qa.size(), qd.size() > 0 ? qd[0] : 32'hx, qa.size() > 0 ? qa[0] : 8'hx);
    end
    tests++;
    if (nDone != 1 || finPr != 0) begin
      fails++; $display("FAIL normal_done: got done=%0d prst_at_done=%0d want 1 and 0", nDone, finPr);
    end
  endtask

  task test_zero_len;
    doReset;
    doStart;
    sendWord(32'd0);
    tests++;
    if ({err, program_rst, rx_ready, busy} !== 4'b1100) begin
      fails++; $display("FAIL zero_len_err: got err/prst/rdy/busy=%b want 1100", {err, program_rst, rx_ready, busy});
    end
    sendWord(32'h11223344);
    tick;
    tests++;
    if (qa.size() != 0 || err !== 1'b1) begin
      fails++; $display("FAIL zero_len_nowrite: got writes=%0d err=%b want 0 and 1", qa.size(), err);
    end
    doStart;
    tests++;
    if ({err, busy, program_rst} !== 3'b011) begin
      fails++; $display("FAIL zero_len_restart: got err/busy/prst=%b want 011", {err, busy, program_rst});
    end
  endtask

  task test_oversize;
    int bad;
    doReset;
    doStart;
    sendWord(32'h101);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL oversize_101: got err=%b busy=%b want 1 0", err, busy);
    end
    doStart;
    sendWord(32'h100);
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL oversize_100_accept: got err=%b busy=%b want 0 1", err, busy);
    end
    for (int i = 0; i < 256; i++) sendWord(32'hC0DE0000 + i);
    tick; tick;
    bad = 0;
    for (int i = 0; i < qa.size() && i < 256; i++)
      if (qa[i] !== i[7:0] || qd[i] !== 32'hC0DE0000 + i) bad++;
    tests++;
    if (qa.size() != 256 || bad != 0 || qa[qa.size()-1] !== 8'hFF) begin
      fails++; $display("FAIL oversize_256_writes: got %0d writes, %0d wrong, want 256 writes ending at ff", qa.size(), bad);
    end
    tests++;
    if (nDone != 1) begin
      fails++; $display("FAIL oversize_done: got %0d done pulses want 1", nDone);
    end
  endtask

  task test_gapped;
    int k;
    doReset;
    doStart;
    k = 0;
    for (int t = 0; t < 2000 && k < 12; t++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = rx_valid ? gw[k/4][8*(k%4)+:8] : 8'($urandom);
      tick;
      if (rx_valid) k++;
    end
    rx_valid = 0;
    tick; tick;
    tests++;
    if (k != 12 || qa.size() != 2 || qa[0] !== 8'd0 || qd[0] !== 32'h00500513 || qa[1] !== 8'd1 || qd[1] !== 32'h00A00593 || nDone != 1) begin
      fails++; $display("FAIL gapped_writes: got bytes=%0d writes=%0d done=%0d want 12 2 1 with same words", k, qa.size(), nDone);
    end
  endtask

  task test_reset_midload;
    doReset;
    doStart;
    sendWord(32'd2);
    sendWord(32'h00500513);
    sendByte(8'h93); sendByte(8'h05);
    processor_rst = 1;
    tick;
    processor_rst = 0;
    tests++;
    if ({rx_ready, im_we, program_rst, busy, done, err} !== 6'b001000 || im_addr !== 8'd0 || im_wdata !== 32'd0) begin
      fails++; $display("FAIL midload_reset_state: got ctl=%b addr=%h data=%h want 001000 00 00000000",
        {rx_ready, im_we, program_rst, busy, done, err}, im_addr, im_wdata);
    end
    sendByte(8'hA0); sendByte(8'h00);
    sendWord(32'h12345678);
    tick;
    tests++;
    if (qa.size() != 1 || program_rst !== 1'b1 || nDone != 0) begin
      fails++; $display("FAIL midload_no_more_writes: got writes=%0d prst=%b done=%0d want 1 1 0", qa.size(), program_rst, nDone);
    end
  endtask

  task test_start_during_load;
    doReset;
    doStart;
    sendWord(32'd2);
    sendByte(8'h13); sendByte(8'h05);
    start = 1; sendByte(8'h50); start = 0;
    start = 1; tick; start = 0;
    sendByte(8'h00);
    start = 1; sendWord(32'h00A00593); start = 0;
    tick; tick;
    tests++;
    if (qa.size() != 2 || qa[0] !== 8'd0 || qd[0] !== 32'h00500513 || qa[1] !== 8'd1 || qd[1] !== 32'h00A00593 || nDone != 1) begin
      fails++; $display("FAIL start_during_load: got writes=%0d done=%0d want 2 writes 00500513@00 00A00593@01 and 1 done", qa.size(), nDone);
    end
    tests++;
    if (busy !== 1'b0 || program_rst !== 1'b0) begin
      fails++; $display("FAIL start_during_load_idle: got busy=%b prst=%b want 0 0", busy, program_rst);
    end
  endtask

  initial begin
    processor_rst = 1; start = 0; rx_valid = 0; rx_data = 0;
    test_reset;
    test_normal;
    test_zero_len;
    test_oversize;
    test_gapped;
    test_reset_midload;
    test_start_during_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port processor_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a load; sampled only in IDLE or ERR.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: the upstream byte source has a byte on rx_data.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the incoming byte stream.
REQ-007 The block SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 The block SHALL have port im_we, output, 1 bit: instruction-memory write enable, one-cycle pulse per word.
REQ-009 The block SHALL have port im_addr, output, ADDR_W bits: instruction-memory word address.
REQ-010 The block SHALL have port im_wdata, output, 32 bits: instruction word to write.
REQ-011 The block SHALL have port program_rst, output, 1 bit: holds the processor pipeline in reset while high.
REQ-012 The block SHALL have port busy, output, 1 bit: high in HDR and DATA.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a load completes successfully.
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for a bad header.

Function
REQ-015 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-016 rx_ready SHALL be 1 exactly in the HDR and DATA states; rx_data is ignored otherwise.
REQ-017 The states SHALL be IDLE, HDR, DATA, FIN and ERR.
REQ-018 IDLE SHALL go to HDR on start=1; HDR entry clears the byte counter, word counter, address and err.
REQ-019 In HDR, the loader SHALL accept 4 bytes, little-endian, forming LEN, a 32-bit word count.
REQ-020 After the 4th header byte: if LEN==0 or LEN>2^ADDR_W, the next state SHALL be ERR; otherwise DATA.
REQ-021 In DATA, every 4 accepted bytes SHALL form one word, little-endian: the first byte goes to bits [7:0].
REQ-022 On the cycle after a word's 4th byte is accepted, the loader SHALL assert im_we=1 for exactly one cycle, with im_wdata=word and im_addr=word index (0,1,2,...).
REQ-023 im_addr SHALL increment after each write, and the address arithmetic is ADDR_W wide.
REQ-024 rx_ready SHALL stay 1 during an im_we cycle, so back-to-back bytes are accepted with no bubbles.
REQ-025 After the write of word LEN-1, the state SHALL go to FIN; FIN lasts one cycle, with done=1 and program_rst=0, and then goes to IDLE.
REQ-026 program_rst SHALL be 1 from the reset state through HDR and DATA, 0 from FIN onward in IDLE, and 1 again on the cycle after start is accepted.
REQ-027 In ERR, err SHALL be 1, program_rst SHALL be 1, and rx_ready SHALL be 0; the block leaves ERR only on start=1 (to HDR) or on processor_rst.
REQ-028 start SHALL be ignored in HDR, DATA and FIN.
REQ-029 rx_valid may drop mid-word or mid-header; partial assembly SHALL be held indefinitely with no timeout.
REQ-030 im_we SHALL never be asserted outside DATA/FIN boundaries, and never more than LEN times per load.

Reset
REQ-031 When processor_rst=1 at a clock edge, the block SHALL set state=IDLE, program_rst=1, rx_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, and clear all counters.
REQ-032 processor_rst SHALL take priority over all other inputs, including in the middle of a load; a partially loaded memory is not erased and no further im_we occurs.

Verification
REQ-033 The bench SHALL check a normal load: start, header bytes 02 00 00 00, then 13 05 50 00 93 05 A0 00 sent back-to-back -> im_we at addr 0 with data 0x00500513, then at addr 1 with data 0x00A00593; done pulses once; program_rst falls in the FIN cycle.
REQ-034 The bench SHALL check a zero-length header: bytes 00 00 00 00 -> ERR, err=1, program_rst=1, no im_we; a later start clears err and re-enters HDR.
REQ-035 The bench SHALL check an oversize header with ADDR_W=8: LEN=0x101 -> ERR; with LEN=0x100, 256 writes occur and im_addr reaches 0xFF.
REQ-036 The bench SHALL check a gapped stream: rx_valid is toggled randomly 50% of the time -> identical writes to the back-to-back case and no duplicated or dropped bytes.
REQ-037 The bench SHALL check reset mid-load: processor_rst after 6 data bytes -> all outputs at reset values the next cycle, no further im_we, and program_rst=1.
REQ-038 The bench SHALL check start during a load: start pulses in DATA -> ignored; address and byte counting continue unchanged.
